fa_resp_checker: RTL and testbench

//  Clocked response side of the e8bit_fa adder path. It latches one operand request,

---
 rtl/fa_resp_checker.sv | 97 +++++++++
 tb/tb_fa_resp_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fa_resp_checker.sv
// fa_resp_checker: launches one adder operation, watches Sout/Cout until they hold the
// expected value for STABLE_CYC samples or MAX_WAIT expires, then reports the result.
module fa_resp_checker #(
    parameter int WIDTH      = 8,
    parameter int MAX_WAIT   = 15,
    parameter int STABLE_CYC = 2,
    parameter int LAT_W      = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [LAT_W-1:0] latency,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int SW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_l, b_l;
    logic             cin_l;
    logic [WIDTH:0]   exp_v;
    logic [LAT_W-1:0] wait_cnt, wait_nx;
    logic [SW-1:0]    stable_cnt, stable_nx;
    logic             settled, expired;

    always_comb begin
        wait_nx   = wait_cnt + 1'b1;
        stable_nx = ({cout_in, sum_in} == exp_v) ? stable_cnt + 1'b1 : '0;
        settled   = stable_nx == SW'(STABLE_CYC);
        expired   = wait_nx == LAT_W'(MAX_WAIT);
        busy      = state != IDLE;
        done      = state == REPORT;
        state_nx  = state == IDLE   ? (start ? LAUNCH : IDLE) :
                    state == LAUNCH ? WAIT :
                    state == WAIT   ? ((settled || expired) ? REPORT : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            a_l        <= '0;
            b_l        <= '0;
            cin_l      <= 1'b0;
            exp_v      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            wait_cnt   <= '0;
            stable_cnt <= '0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            latency    <= '0;
            err_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_l   <= a_in;
                b_l   <= b_in;
                cin_l <= cin_in;
                exp_v <= {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin_in};
            end
            if (state == LAUNCH) begin
                op_a       <= a_l;
                op_b       <= b_l;
                op_cin     <= cin_l;
                wait_cnt   <= '0;
                stable_cnt <= '0;
            end
            if (state == WAIT) begin
                wait_cnt   <= wait_nx;
                stable_cnt <= stable_nx;
            end
            // results are captured on entry to REPORT so they are valid alongside done
            if (state == WAIT && (settled || expired)) begin
                pass    <= settled;
                timeout <= !settled;
                latency <= settled ? wait_nx - LAT_W'(STABLE_CYC - 1) : LAT_W'(MAX_WAIT);
                if (!settled && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fa_resp_checker.sv
// tb_fa_resp_checker: drives a modelled adder response per WAIT sample and checks the
// report against a window-search reference; a second ERR_W=2 instance checks saturation.
module tb_fa_resp_checker;
    localparam int MW = 15;
    localparam int SC = 2;

    logic       clk = 1'b0, rstn = 1'b0, start = 1'b0, cin_in = 1'b0, cout_in = 1'b0;
    logic [7:0] a_in = '0, b_in = '0, sum_in = '0;
    logic [7:0] op_a, op_b, s_op_a, s_op_b;
    logic       op_cin, busy, done, pass, timeout;
    logic       s_op_cin, s_busy, s_done, s_pass, s_timeout;
    logic [3:0] latency, s_latency;
    logic [15:0] err_cnt;
    logic [1:0] s_err;

    fa_resp_checker dut (
        .clk(clk), .rstn(rstn), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .sum_in(sum_in), .cout_in(cout_in),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .latency(latency),
        .err_cnt(err_cnt)
    );

    fa_resp_checker #(.ERR_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .op_a(s_op_a), .op_b(s_op_b), .op_cin(s_op_cin), .sum_in(sum_in), .cout_in(cout_in),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .latency(s_latency),
        .err_cnt(s_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_err = 0;
    logic m_pass = 1'b0, m_to = 1'b0;
    logic [3:0] m_lat = '0;

    typedef struct {
        logic [7:0]  a, b;
        logic        cin;
        logic [15:0] mask;
        bit          mid, rep;
        int          exp_k;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sample index at which STABLE_CYC consecutive good samples first complete, 0 if never
    function automatic int settle_at(input logic [15:0] mask);
        bit ok;
        for (int k = SC; k <= MW; k++) begin
            ok = 1'b1;
            for (int j = k - SC + 1; j <= k; j++) if (!mask[j-1]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_op"}, {op_a, op_b, op_cin}, 0);
        chk({tag, "_flags"}, {busy, done, pass, timeout}, 0);
        chk({tag, "_lat"}, latency, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_serr"}, s_err, 0);
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [15:0] mask, input bit mid, input bit rep, input int exp_k);
        logic [8:0] e;
        int got;
        e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        got = 0;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("launch_busy", busy, 1);
        chk("hold_pass", pass, m_pass);
        chk("hold_timeout", timeout, m_to);
        chk("hold_latency", latency, m_lat);
        @(negedge clk);
        for (int k = 1; k <= MW + 3 && got == 0; k++) begin
            {cout_in, sum_in} = (k <= 16 && mask[k-1]) ? e : e ^ 9'(1 + $urandom_range(0, 510));
            if (mid && k == 2) begin
                start = 1'b1; a_in = ~a; b_in = b + 8'd1; cin_in = ~cin;
            end
            @(negedge clk);
            start = 1'b0;
            if (done) got = k;
        end
        chk("done_sample", got, exp_k != 0 ? exp_k : MW);
        m_pass = exp_k != 0;
        m_to   = !m_pass;
        m_lat  = m_pass ? 4'(exp_k - SC + 1) : 4'(MW);
        if (!m_pass) m_err++;
        chk("pass", pass, m_pass);
        chk("timeout", timeout, m_to);
        chk("latency", latency, m_lat);
        chk("err_cnt", err_cnt, m_err);
        chk("err_cnt_sat", s_err, m_err > 3 ? 3 : m_err);
        chk("ops", {op_a, op_b, op_cin}, {a, b, cin});
        chk("report_busy", busy, 1);
        if (rep) begin
            start = 1'b1; a_in = 8'h5A;
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        tv[0] = '{8'hFF, 8'h01, 1'b0, 16'hFFFC, 1'b0, 1'b0, 4};
        tv[1] = '{8'h05, 8'h03, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
        tv[2] = '{8'h80, 8'h80, 1'b1, 16'hFFFA, 1'b0, 1'b0, 5};
        tv[3] = '{8'h12, 8'h34, 1'b1, 16'hFFF0, 1'b1, 1'b0, 6};
        tv[4] = '{8'hFF, 8'hFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 2};
        tv[5] = '{8'h7F, 8'h01, 1'b0, 16'h6000, 1'b0, 1'b0, 15};
        tv[6] = '{8'h00, 8'h00, 1'b0, 16'h4000, 1'b0, 1'b0, 0};
        tv[7] = '{8'hAA, 8'h55, 1'b1, 16'h8000, 1'b0, 1'b1, 0};

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;

        foreach (tv[i]) run(tv[i].a, tv[i].b, tv[i].cin, tv[i].mask, tv[i].mid, tv[i].rep, tv[i].exp_k);

        // abort a failing check mid-WAIT with reset
        @(negedge clk);
        a_in = 8'h05; b_in = 8'h03; cin_in = 1'b0; start = 1'b1;
        {cout_in, sum_in} = 9'h000;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rstn = 1'b1;
        m_err = 0; m_pass = 1'b0; m_to = 1'b0; m_lat = '0;
        run(8'hFF, 8'h01, 1'b0, 16'hFFFC, 1'b0, 1'b0, 4);

        // four failures drive the 2-bit counter into saturation
        repeat (4) run(8'($urandom), 8'($urandom), 1'($urandom), 16'h0000, 1'b0, 1'b0, 0);

        for (int n = 0; n < 25; n++) begin
            logic [15:0] m;
            int s;
            s = $urandom_range(1, 17);
            m = (s <= 16) ? 16'(16'hFFFF << (s - 1)) : 16'h0000;
            if ($urandom_range(0, 2) == 0) m[$urandom_range(0, 15)] = 1'b0;
            run(8'($urandom), 8'($urandom), 1'($urandom), m,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, settle_at(m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
